timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arb_pkg.sv | 13 +
 rtl/tick_gen.sv | 41 ++++
 rtl/timer_arbiter.sv | 133 +++++++++++++
 tb/tb_timer_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arb_pkg.sv
// Shared types and defaults for the two-requester timer arbiter.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned TICK_DIV_DEF = 100_000_000;
  localparam int unsigned DUR_W_DEF    = 4;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_gen
  import timer_arb_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count is held at zero whenever the timer is not running.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting a shared tick timer to one of two requesters.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned DUR_W    = DUR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [2*DUR_W-1:0] dur,
  output logic [1:0]         grant,
  output logic [1:0]         done,
  output logic               busy,
  output logic [DUR_W-1:0]   remaining,
  output logic               flash
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             flash_q, flash_d;
  logic [DUR_W-1:0] rem_q, rem_d;

  logic             win;
  logic [DUR_W-1:0] win_dur;
  logic             load;
  logic             tick;

  assign win     = (req == 2'b11) ? ~last_q : req[1];
  assign win_dur = win ? dur[2*DUR_W-1:DUR_W] : dur[DUR_W-1:0];

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(state_q == RUN),
    .clear (load),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    flash_d = flash_q;
    rem_d   = rem_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          load    = 1'b1;
          owner_d = win;
          grant_d = {win, ~win};
          rem_d   = win_dur;
          flash_d = 1'b0;
          busy_d  = 1'b1;
          state_d = (win_dur == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          flash_d = 1'b0;
          rem_d   = '0;
          last_d  = owner_q;
        end else if (tick) begin
          rem_d   = rem_q - 1'b1;
          flash_d = ~flash_q;
          if (rem_q == DUR_W'(1)) begin
            state_d = DONE;
            done_d  = grant_q;
          end
        end
      end
      DONE: begin
        // A zero-length grant arrives here without its pulse; emit it one cycle later.
        if (done_q != 2'b00) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          flash_d = 1'b0;
          rem_d   = '0;
          last_d  = owner_q;
        end else begin
          done_d = grant_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      flash_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      flash_q <= flash_d;
      rem_q   <= rem_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign flash     = flash_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter with TICK_DIV=4: output changes are matched against queued expectations.
module tb_timer_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] dur;
  logic [1:0] grant;
  logic [1:0] done;
  logic       busy;
  logic [3:0] remaining;
  logic       flash;

  timer_arbiter #(
    .TICK_DIV(4),
    .DUR_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dur      (dur),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .remaining(remaining),
    .flash    (flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dt = cycles since the previous output change; 0 means not checked.
  typedef struct packed {
    logic [1:0]  g;
    logic [1:0]  d;
    logic        b;
    logic        f;
    logic [3:0]  r;
    int unsigned dt;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         e;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned cyc     = 0;
  int unsigned last_cyc = 0;
  int unsigned ev_idx  = 0;
  int unsigned dt;
  logic [9:0]  prev_snap = '0;
  logic [9:0]  cur_snap;

  function automatic void push_ev(input logic [1:0] g, input logic [1:0] d, input logic b,
                                  input logic f, input logic [3:0] r, input int unsigned t);
    ev_t x;
    x.g = g; x.d = d; x.b = b; x.f = f; x.r = r; x.dt = t;
    exp_q.push_back(x);
  endfunction

  always @(negedge clk) begin
    cyc++;
    cur_snap = {grant, done, busy, flash, remaining};
    if (rst) begin
      prev_snap = cur_snap;
      last_cyc  = cyc;
    end else if (cur_snap != prev_snap) begin
      dt        = cyc - last_cyc;
      last_cyc  = cyc;
      prev_snap = cur_snap;
      ev_idx++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event%0d: got grant=%b done=%b busy=%b flash=%b rem=%0d dt=%0d, required no change",
                 ev_idx, grant, done, busy, flash, remaining, dt);
      end else begin
        e = exp_q.pop_front();
        if (grant === e.g && done === e.d && busy === e.b && flash === e.f &&
            remaining === e.r && (e.dt == 0 || e.dt == dt)) begin
          n_pass++;
        end else begin
          $display("FAIL event%0d: got grant=%b done=%b busy=%b flash=%b rem=%0d dt=%0d, required grant=%b done=%b busy=%b flash=%b rem=%0d dt=%0d",
                   ev_idx, grant, done, busy, flash, remaining, dt,
                   e.g, e.d, e.b, e.f, e.r, e.dt);
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    step(3);
  endtask

  task automatic check_zero(input string name);
    n_total++;
    if (grant === 2'b00 && done === 2'b00 && busy === 1'b0 && flash === 1'b0 && remaining === 4'd0) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got grant=%b done=%b busy=%b flash=%b rem=%0d, required all zero",
               name, grant, done, busy, flash, remaining);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    dur = 8'h00;
    step(2);
    check_zero("reset_state");
    rst = 1'b0;
    step(2);

    // Both requesting from reset: 0 first, then 1, then 0 again, which is aborted.
    push_ev(2'b01, 2'b00, 1'b1, 1'b0, 4'd2, 0);
    push_ev(2'b01, 2'b00, 1'b1, 1'b1, 4'd1, 4);
    push_ev(2'b01, 2'b01, 1'b1, 1'b0, 4'd0, 4);
    push_ev(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1);
    push_ev(2'b10, 2'b00, 1'b1, 1'b0, 4'd1, 1);
    push_ev(2'b10, 2'b10, 1'b1, 1'b1, 4'd0, 4);
    push_ev(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1);
    push_ev(2'b01, 2'b00, 1'b1, 1'b0, 4'd2, 1);
    push_ev(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1);
    req = 2'b11;
    dur = {4'd1, 4'd2};
    step(17);
    req = 2'b00;
    drain("round_robin");

    // Single run of 3 ticks; dur changes mid-run must not matter.
    push_ev(2'b01, 2'b00, 1'b1, 1'b0, 4'd3, 0);
    push_ev(2'b01, 2'b00, 1'b1, 1'b1, 4'd2, 4);
    push_ev(2'b01, 2'b00, 1'b1, 1'b0, 4'd1, 4);
    push_ev(2'b01, 2'b01, 1'b1, 1'b1, 4'd0, 4);
    push_ev(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1);
    req = 2'b01;
    dur = 8'h03;
    step(3);
    dur = 8'h09;
    step(10);
    req = 2'b00;
    drain("run3");

    // Zero duration on requester 1.
    push_ev(2'b10, 2'b00, 1'b1, 1'b0, 4'd0, 0);
    push_ev(2'b10, 2'b10, 1'b1, 1'b0, 4'd0, 1);
    push_ev(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1);
    req = 2'b10;
    dur = 8'h00;
    step(2);
    req = 2'b00;
    drain("zero_dur");

    // Owner drops its request during RUN.
    push_ev(2'b01, 2'b00, 1'b1, 1'b0, 4'd5, 0);
    push_ev(2'b01, 2'b00, 1'b1, 1'b1, 4'd4, 4);
    push_ev(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 2);
    req = 2'b01;
    dur = 8'h05;
    step(6);
    req = 2'b00;
    drain("abort");

    // Reset while remaining=2, then a normal run afterwards.
    push_ev(2'b01, 2'b00, 1'b1, 1'b0, 4'd3, 0);
    push_ev(2'b01, 2'b00, 1'b1, 1'b1, 4'd2, 4);
    req = 2'b01;
    dur = 8'h03;
    step(6);
    rst = 1'b1;
    #1;
    check_zero("reset_mid_run");
    step(2);
    check_zero("reset_held");
    dur = 8'h02;
    push_ev(2'b01, 2'b00, 1'b1, 1'b0, 4'd2, 0);
    push_ev(2'b01, 2'b00, 1'b1, 1'b1, 4'd1, 4);
    push_ev(2'b01, 2'b01, 1'b1, 1'b0, 4'd0, 4);
    push_ev(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1);
    rst = 1'b0;
    step(9);
    req = 2'b00;
    drain("after_reset");

    // Maximum duration: remaining walks 15..0 without wrapping.
    push_ev(2'b01, 2'b00, 1'b1, 1'b0, 4'd15, 0);
    for (int k = 1; k <= 15; k++) begin
      push_ev(2'b01, (k == 15) ? 2'b01 : 2'b00, 1'b1, (k % 2 == 1), 4'(15 - k), 4);
    end
    push_ev(2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 1);
    req = 2'b01;
    dur = 8'h0F;
    step(61);
    req = 2'b00;
    drain("max_dur");

    step(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
